// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the sequencer state encoding and the saturation limit of the sequence counter.
// Imported by reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0] SEQ_CNT_MAX = 8'd255;

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchroniser for a single level signal from an asynchronous source.
// Latency: 2 clock edges. No backpressure (free-running level path).
// Ports: i_clk, i_rst (async active-high, clears both flops), i_d (async level), o_q (synchronised).
module rst_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / soft reset sequencer: holds N_CH resets, then releases them one by one, bit 0 first.
// Latency: rst_out[k] falls HOLD_CYCLES + k*STEP_CYCLES edges after timing starts; outputs registered.
// Backpressure: none; a high soft request restarts the sequence and pins it in HOLD while high.
// Optional macro RESET_SEQ_SYNC_EN: soft request passes through a 2-flop synchroniser (+2 edges).
// Ports: i_clk, i_rst (async active-high), i_soft_req (level), o_rst_out[N_CH], o_busy, o_done,
//        o_seq_count (completed sequences since i_rst, saturating at 255).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int HOLD_CYCLES = 1048576,
  parameter int STEP_CYCLES = 1024,
  parameter int CNT_W       = 21
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_soft_req,
  output logic [N_CH-1:0] o_rst_out,
  output logic            o_busy,
  output logic            o_done,
  output logic [7:0]      o_seq_count
);

  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MAX_PERIOD = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  // The counter must be able to hold the longest terminal count.
  generate
    if ((64'd1 << CNT_W) <= 64'(MAX_PERIOD - 1)) begin : g_cnt_w_too_small
      $error("reset_sequencer: CNT_W too small for HOLD_CYCLES/STEP_CYCLES");
    end
  endgenerate

  logic w_soft_req;

`ifdef RESET_SEQ_SYNC_EN
  rst_sync_2ff u_soft_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_soft_req),
    .o_q   (w_soft_req)
  );
`else
  assign w_soft_req = i_soft_req;
`endif

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CH_W-1:0]  r_ch;
  logic [N_CH-1:0]  r_rst_out;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_seq_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_rst_out   <= '1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_seq_count <= 8'd0;
    end else if (w_soft_req) begin
      // Soft request overrides any release scheduled for this edge.
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_rst_out <= '1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_rst_out[0] <= 1'b0;
            r_cnt        <= '0;
            r_ch         <= CH_W'(1);
            if (N_CH == 1) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (r_seq_count != SEQ_CNT_MAX) r_seq_count <= r_seq_count + 8'd1;
            end else begin
              r_state <= STEP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STEP: begin
          if (r_cnt == STEP_LAST) begin
            // Clear only the channel currently being released.
            r_rst_out <= r_rst_out & ~(N_CH'(1) << r_ch);
            r_cnt     <= '0;
            r_ch      <= r_ch + CH_W'(1);
            if (r_ch == CH_LAST) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (r_seq_count != SEQ_CNT_MAX) r_seq_count <= r_seq_count + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // RUN: everything released, hold outputs steady.
        end
      endcase
    end
  end

  assign o_rst_out   = r_rst_out;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_seq_count = r_seq_count;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int N_CH = 3;
  localparam int HOLD = 8;
  localparam int STEP = 4;
  localparam int LAST = HOLD + (N_CH - 1) * STEP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_req = 1'b0;
  logic       soft_off = 1'b0;
  logic [2:0] rst_out;
  logic       busy, done;
  logic [7:0] seq_count;
  logic [0:0] rst_out1;
  logic       busy1, done1;
  logic [7:0] seq_count1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.N_CH(N_CH), .HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP), .CNT_W(21)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_soft_req(soft_req),
    .o_rst_out(rst_out), .o_busy(busy), .o_done(done), .o_seq_count(seq_count)
  );

  reset_sequencer #(.N_CH(1), .HOLD_CYCLES(1), .STEP_CYCLES(1), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_soft_req(soft_off),
    .o_rst_out(rst_out1), .o_busy(busy1), .o_done(done1), .o_seq_count(seq_count1)
  );

  // Reference model: t = edges since timing last (re)started; a channel k is
  // released once t reaches HOLD + k*STEP; a sequence completes when t hits LAST.
  int   m_t;
  int   m_seq;
  logic m_s1, m_s2, m_eff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_seq = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
`ifdef RESET_SEQ_SYNC_EN
      m_eff = m_s2; m_s2 = m_s1; m_s1 = soft_req;
`else
      m_eff = soft_req;
`endif
      if (m_eff) m_t = 0;
      else begin
        if (m_t < 1000000) m_t = m_t + 1;
        if (m_t == LAST) m_seq = (m_seq < 255) ? m_seq + 1 : 255;
      end
    end
  end

  function automatic logic [2:0] exp_rst_out(input int t);
    logic [2:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = (t < HOLD + k * STEP);
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_val("rst_out", 32'(rst_out), 32'(exp_rst_out(m_t)));
    check_val("done", 32'(done), 32'(m_t >= LAST));
    check_val("busy", 32'(busy), 32'(m_t < LAST));
    check_val("seq_count", 32'(seq_count), 32'(m_seq));
  endtask

  // Drive soft_req for one cycle, then check at the following negedge.
  task automatic cyc(input logic s);
    soft_req = s;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int hold_left;
    int r;
    hold_left = 0;

    // Reset state while rst is held.
    repeat (3) @(negedge clk);
    check_val("reset_rst_out", 32'(rst_out), 32'h7);
    check_val("reset_busy", 32'(busy), 32'h1);
    check_val("reset_done", 32'(done), 32'h0);
    check_val("reset_seq", 32'(seq_count), 32'h0);
    check_val("reset_rst_out1", 32'(rst_out1), 32'h1);
    check_val("reset_done1", 32'(done1), 32'h0);

    // Power-on sequence with fixed edge landmarks.
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      check_model();
      if (e == 1) begin
        check_val("ch1_rst_out_e1", 32'(rst_out1), 32'h0);
        check_val("ch1_done_e1", 32'(done1), 32'h1);
        check_val("ch1_busy_e1", 32'(busy1), 32'h0);
        check_val("ch1_seq_e1", 32'(seq_count1), 32'h1);
      end
      if (e == 7)  check_val("e7_rst_out", 32'(rst_out), 32'h7);
      if (e == 8)  check_val("e8_rst_out", 32'(rst_out), 32'h6);
      if (e == 12) check_val("e12_rst_out", 32'(rst_out), 32'h4);
      if (e == 16) begin
        check_val("e16_rst_out", 32'(rst_out), 32'h0);
        check_val("e16_done", 32'(done), 32'h1);
        check_val("e16_busy", 32'(busy), 32'h0);
        check_val("e16_seq", 32'(seq_count), 32'h1);
      end
    end

    // Async reset in the middle of a sequence, seen with no clock edge.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) cyc(1'b0);
    #1 rst = 1'b1;
    #1;
    check_val("midrst_rst_out", 32'(rst_out), 32'h7);
    check_val("midrst_done", 32'(done), 32'h0);
    check_val("midrst_seq", 32'(seq_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) cyc(1'b0);
    check_val("after_midrst_seq", 32'(seq_count), 32'h1);

    // One-cycle soft request from RUN.
    cyc(1'b1);
    for (int e = 0; e < 24; e++) cyc(1'b0);
    check_val("soft_pulse_seq", 32'(seq_count), 32'h2);

    // Soft request held 20 cycles during STEP.
    for (int e = 0; e < 10; e++) cyc(1'b0);
    for (int e = 0; e < 20; e++) cyc(1'b1);
    for (int e = 0; e < 24; e++) cyc(1'b0);

    // Randomised soft request activity: pulses and long holds.
    for (int i = 0; i < 800; i++) begin
      if (hold_left > 0) begin
        hold_left--;
        cyc(1'b1);
      end else begin
        r = $urandom_range(0, 39);
        if (r == 0) begin
          hold_left = $urandom_range(5, 25);
          cyc(1'b1);
        end else cyc(r < 3);
      end
    end
    for (int e = 0; e < 24; e++) cyc(1'b0);

    // Saturation: enough soft-triggered sequences to pass 255.
    for (int i = 0; i < 262; i++) begin
      cyc(1'b1);
      for (int e = 0; e < 20; e++) cyc(1'b0);
    end
    check_val("sat_seq", 32'(seq_count), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
